// File: rtl/pipe_fwd_mux.sv
// Operand forwarding mux for one register read port. The youngest matching
// in-flight result wins, and a not-ready winner raises a load-use stall.
module pipe_fwd_mux #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 3,
  parameter int SW    = $clog2(NSRC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [AW-1:0]         rs_addr,
  input  logic [WIDTH-1:0]      rf_value,
  input  logic [NSRC-1:0]       src_we,
  input  logic [NSRC*AW-1:0]    src_addr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ready,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_sel,
  output logic                  hazard_stall,
  output logic [15:0]           hazard_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [NSRC-1:0]  match;
  logic             hit;
  logic             win_ready;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    sel_code;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [15:0]      hazard_cnt_q, hazard_cnt_d;

  always_comb begin
    match = '0;
    for (int i = 0; i < NSRC; i++) begin
      match[i] = src_we[i] && (src_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0);
    end
  end

  // Walk from oldest to youngest so the lowest-index match is assigned last.
  always_comb begin
    hit       = 1'b0;
    win_ready = 1'b1;
    sel_data  = rf_value;
    sel_code  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit       = 1'b1;
        win_ready = src_ready[i];
        sel_data  = src_data[i*WIDTH +: WIDTH];
        sel_code  = SW'(i + 1);
      end
    end
  end

  assign hazard_stall = in_valid && hit && !win_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (flush || (!stall_in && hazard_stall)) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_sel_d   = '0;
    end else if (!stall_in) begin
      out_valid_d = in_valid;
      out_data_d  = sel_data;
      out_sel_d   = sel_code;
    end
  end

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (hazard_stall && (hazard_cnt_q != CNT_MAX)) begin
      hazard_cnt_d = hazard_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      hazard_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sel    = out_sel_q;
  assign hazard_cnt = hazard_cnt_q;

endmodule
